// File: rtl/hex_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_mux_if
// Brief    : Bundle of the scanner's control inputs and display outputs.
//            master = whoever drives enable/load/value_in,
//            slave  = the scanner itself.
// Revision : 1.0 - initial release
// ============================================================================
interface hex_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic [3:0]            hex_out;
  logic [DIGITS-1:0]     digit_an;
  logic                  frame;

  modport master (
    output enable, load, value_in,
    input  hex_out, digit_an, frame
  );

  modport slave (
    input  enable, load, value_in,
    output hex_out, digit_an, frame
  );
endinterface
`default_nettype wire

// File: rtl/hex_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_mux
// Brief    : Time-multiplexed hex digit scanner for a common-anode display.
//            Holds a DIGITS-nibble value in a shadow register and presents one
//            nibble at a time on hex_out with the matching active-low digit
//            enable. Each digit stays lit for DIV clocks; frame pulses once per
//            full scan, one edge after the wrap from the last digit to digit 0.
//            Optional build macro HEX_SCAN_ZERO_BLANK_EN enables leading-zero
//            blanking (digit 0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module hex_scan_mux #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  wire           clk,
  input  wire           resetn,
  hex_scan_mux_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic [0:0] {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t              state_q,  state_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic [PRE_W-1:0]    pre_q,    pre_d;
  logic                wrap_q,   wrap_d;
  logic [3:0]          hex_q,    hex_d;
  logic [DIGITS-1:0]   an_q,     an_d;
  logic                frame_q,  frame_d;

  logic                w_tick;
  logic [DIGITS-1:0]   w_onehot;
  logic [3:0]          w_nibble;
  logic [DIGITS-1:0]   w_blank;
  logic                w_blank_sel;

  // Prescaler only runs in SCAN; in OFF it sits at 0, and DIV >= 2 keeps tick low there.
  assign w_tick = (pre_q == PRE_LAST);

  // Shadow register captures value_in on any load strobe, independent of state.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.load) begin
      shadow_d = bus.value_in;
    end
  end

  // Scan FSM: entering or leaving SCAN restarts the scan at digit 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    case (state_q)
      ST_OFF: begin
        idx_d = '0;
        pre_d = '0;
        if (bus.enable) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!bus.enable) begin
          // Disable wins over a coincident tick, so no frame is flagged.
          state_d = ST_OFF;
          idx_d   = '0;
          pre_d   = '0;
        end else if (w_tick) begin
          pre_d  = '0;
          wrap_d = (idx_q == IDX_LAST);
          idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        idx_d   = '0;
        pre_d   = '0;
      end
    endcase
  end

  // Decode the current digit index into a one-hot lane and pick its nibble.
  always_comb begin
    w_onehot = '0;
    w_nibble = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_nibble    = shadow_q[i*4 +: 4];
      end
    end
  end

`ifdef HEX_SCAN_ZERO_BLANK_EN
  // A digit above 0 is blank when it and every more significant nibble are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_lsd
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = ~|shadow_q[4*DIGITS-1:4*gi];
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_blank_sel = |(w_onehot & w_blank);

  // Outputs come from pre-edge state/idx/shadow so nibble and enable always move together.
  always_comb begin
    hex_d   = 4'h0;
    an_d    = '1;
    frame_d = wrap_q;
    if ((state_q == ST_SCAN) && !w_blank_sel) begin
      hex_d = w_nibble;
      an_d  = ~w_onehot;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_OFF;
      shadow_q <= '0;
      idx_q    <= '0;
      pre_q    <= '0;
      wrap_q   <= 1'b0;
      hex_q    <= 4'h0;
      an_q     <= '1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      pre_q    <= pre_d;
      wrap_q   <= wrap_d;
      hex_q    <= hex_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.hex_out  = hex_q;
  assign bus.digit_an = an_q;
  assign bus.frame    = frame_q;

endmodule
`default_nettype wire
